// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin lock arbiter letting NREQ message sources share one UART transmitter
module tx_arbiter #(
  parameter int NREQ = 3,
  parameter int START_TO = 16,
  parameter int GAP = 0,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_transmit,
  output logic [7:0]        uart_tx_byte,
  input  logic              uart_busy,
  output logic [OW-1:0]     owner,
  output logic              locked,
  output logic              timeout_err
);
  localparam int CW = $clog2(((START_TO > GAP) ? START_TO : GAP) + 1);
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_START, S_BUSY, S_GAP} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_owner, r_rr, w_pick, w_rr_n;
  logic [7:0] r_byte, w_byte;
  logic r_last, r_timeout, w_last, w_ovalid, w_hs, w_to, w_rel;
  logic [NREQ-1:0] w_rot;
  always_comb begin
    w_rot = NREQ'({req_valid, req_valid} >> r_rr);
    w_pick = r_rr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (1'(w_rot >> k))
        w_pick = (int'(r_rr) + k >= NREQ) ? OW'(int'(r_rr) + k - NREQ) : OW'(int'(r_rr) + k);
  end
  assign w_byte = 8'(req_data >> {r_owner, 3'b000});
  assign w_last = 1'(req_last >> r_owner);
  assign w_ovalid = 1'(req_valid >> r_owner);
  assign w_hs = (r_state == S_SEND) && w_ovalid;
  assign w_to = (r_state == S_START) && !uart_busy && (r_cnt == CW'(START_TO - 1));
  assign w_rr_n = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  always_comb begin
    w_state_n = r_state;
    w_rel = 1'b0;
    case (r_state)
      S_IDLE:  w_state_n = |req_valid ? S_SEND : S_IDLE;
      S_SEND:  w_state_n = w_hs ? S_START : S_SEND;
      S_START: w_state_n = uart_busy ? S_BUSY : (w_to ? S_IDLE : S_START);
      S_BUSY: begin
        w_rel = !uart_busy && r_last;
        w_state_n = uart_busy ? S_BUSY : (!r_last ? S_SEND : (GAP > 0 ? S_GAP : S_IDLE));
      end
      S_GAP:   w_state_n = (r_cnt == CW'(GAP - 1)) ? S_IDLE : S_GAP;
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_owner <= '0;
      r_rr <= '0;
      r_byte <= '0;
      r_last <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= (w_state_n == r_state && (r_state == S_START || r_state == S_GAP)) ? r_cnt + 1'b1 : '0;
      r_timeout <= w_to;
      if (r_state == S_IDLE && |req_valid) r_owner <= w_pick;
      if (w_hs) begin
        r_byte <= w_byte;
        r_last <= w_last;
      end
      if (w_rel || w_to) r_rr <= w_rr_n;
    end
  end
  assign req_ready = w_hs ? NREQ'(1) << r_owner : '0;
  assign uart_transmit = (r_state == S_START) && (r_cnt == '0);
  assign uart_tx_byte = r_byte;
  assign owner = r_owner;
  assign locked = (r_state == S_SEND) || (r_state == S_START) || (r_state == S_BUSY);
  assign timeout_err = r_timeout;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed checks of lock, round-robin, timeout, gap and reset behaviour
module tb_tx_arbiter;
  localparam int NREQ = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic uart_transmit, uart_busy, locked, timeout_err;
  logic [7:0] uart_tx_byte;
  logic [1:0] owner;
  int busy_cnt = 0;
  bit model_en = 1'b1;
  int passed = 0;
  int total = 0;
  logic [7:0] tx_q[$];
  int hs_q[$];
  always #5 clk = ~clk;
  assign uart_busy = busy_cnt != 0;
  tx_arbiter #(.NREQ(NREQ), .START_TO(16), .GAP(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_busy(uart_busy), .owner(owner), .locked(locked), .timeout_err(timeout_err)
  );
  always @(posedge clk) begin
    if (uart_transmit && model_en) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (uart_transmit) tx_q.push_back(uart_tx_byte);
    for (int i = 0; i < NREQ; i++)
      if (!rst && 1'(req_valid >> i) && 1'(req_ready >> i)) hs_q.push_back(i);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  function automatic logic sig(input int w);
    return (w == 0) ? locked : ((w == 1) ? uart_busy : timeout_err);
  endfunction
  task automatic wait_for(input string tag, input int w, input logic val);
    int n = 0;
    while (sig(w) !== val && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sig(w), val);
  endtask
  task automatic push(input int i, input logic [7:0] d, input logic l);
    int n = 0;
    req_data = (req_data & ~(24'hFF << (8 * i))) | (24'(d) << (8 * i));
    req_last = l ? (req_last | (3'b1 << i)) : (req_last & ~(3'b1 << i));
    req_valid = req_valid | (3'b1 << i);
    #1;
    while (!(1'(req_ready >> i)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready%0d_wait", i), n < 200, 1);
    @(negedge clk);
    req_valid = req_valid & ~(3'b1 << i);
  endtask
  task automatic expect_hs(input string tag, input int exp);
    int v = -1;
    if (hs_q.size() > 0) v = hs_q.pop_front();
    chk(tag, v, exp);
  endtask
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int v = -1;
    if (tx_q.size() > 0) v = int'(tx_q.pop_front());
    chk(tag, v, exp);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int k, seen, tn;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_byte", uart_tx_byte, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    req_valid = 3'b001;
    req_data[7:0] = 8'h41;
    req_last = 3'b000;
    @(negedge clk);
    chk("t1_ready", req_ready, 3'b001);
    chk("t1_locked", locked, 1);
    chk("t1_owner", owner, 0);
    @(negedge clk);
    chk("t1_transmit", uart_transmit, 1);
    chk("t1_byte", uart_tx_byte, 8'h41);
    chk("t1_ready_off", req_ready, 0);
    req_valid = 3'b000;
    push(0, 8'h42, 1'b1);
    wait_for("t1_unlock", 0, 1'b0);
    chk("t1_pulses", tx_q.size(), 2);
    expect_tx("t1_tx0", 8'h41);
    expect_tx("t1_tx1", 8'h42);
    req_data = 24'h002221;
    req_last = 3'b011;
    req_valid = 3'b011;
    wait_for("t1_relock", 0, 1'b1);
    chk("t1_rr_owner", owner, 1);
    req_valid = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    hs_q.delete();
    fork
      push(0, 8'hA0, 1'b1);
      push(1, 8'hB1, 1'b1);
      push(2, 8'hC2, 1'b1);
    join
    wait_for("t2_unlock", 0, 1'b0);
    expect_hs("t2_first", 0);
    expect_hs("t2_second", 1);
    expect_hs("t2_third", 2);
    expect_tx("t2_tx0", 8'hA0);
    expect_tx("t2_tx1", 8'hB1);
    expect_tx("t2_tx2", 8'hC2);
    fork
      push(0, 8'hD0, 1'b1);
      push(2, 8'hD2, 1'b1);
    join
    wait_for("t2b_unlock", 0, 1'b0);
    expect_hs("t2b_first", 0);
    expect_hs("t2b_second", 2);
    push(1, 8'h11, 1'b0);
    req_data[7:0] = 8'h55;
    req_last[0] = 1'b1;
    req_valid = req_valid | 3'b001;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready[0]) seen++;
    end
    chk("t3_no_ready0", seen, 0);
    chk("t3_owner", owner, 1);
    chk("t3_locked", locked, 1);
    push(1, 8'h12, 1'b1);
    push(0, 8'h55, 1'b1);
    wait_for("t3_unlock", 0, 1'b0);
    expect_hs("t3_first", 1);
    expect_hs("t3_second", 1);
    expect_hs("t3_third", 0);
    tx_q.delete();
    hs_q.delete();
    model_en = 1'b0;
    push(1, 8'h77, 1'b1);
    chk("t4_transmit", uart_transmit, 1);
    k = 0;
    while (!timeout_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_delay", k, 16);
    chk("t4_unlocked", locked, 0);
    chk("t4_pulses", tx_q.size(), 1);
    @(negedge clk);
    chk("t4_pulse_width", timeout_err, 0);
    model_en = 1'b1;
    fork
      push(0, 8'h80, 1'b1);
      push(2, 8'h82, 1'b1);
    join
    wait_for("t4_unlock", 0, 1'b0);
    expect_hs("t4_first", 1);
    expect_hs("t4_next", 2);
    expect_hs("t4_last", 0);
    push(0, 8'h61, 1'b1);
    req_data[7:0] = 8'h62;
    req_valid = req_valid | 3'b001;
    wait_for("t5_busy_hi", 1, 1'b1);
    wait_for("t5_busy_lo", 1, 1'b0);
    k = 0;
    while (!req_ready[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_gap_grant", k, 7);
    @(negedge clk);
    req_valid = 3'b000;
    wait_for("t5_unlock", 0, 1'b0);
    push(0, 8'h99, 1'b0);
    wait_for("t6_busy_hi", 1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_locked", locked, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_transmit", uart_transmit, 0);
    chk("t6_byte", uart_tx_byte, 0);
    chk("t6_owner", owner, 0);
    chk("t6_busy_still", uart_busy, 1);
    rst = 1'b0;
    tn = tx_q.size();
    repeat (12) @(negedge clk);
    chk("t6_no_pulse", tx_q.size(), tn);
    chk("t6_idle", locked, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of message requesters sharing the UART transmitter (2..8).
REQ-002 Parameter START_TO, default 16, cycles allowed for uart_busy to rise after a transmit pulse.
REQ-003 Parameter GAP, default 0, idle cycles inserted after each complete message.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NREQ  bit i: requester i presents a byte.
REQ-007 req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-008 req_last  in  NREQ  bit i: presented byte is the last of its message.
REQ-009 req_ready  out  NREQ  bit i: byte of requester i accepted this cycle.
REQ-010 uart_transmit  out  1  one-cycle start pulse to the UART transmitter.
REQ-011 uart_tx_byte  out  8  byte to transmit.
REQ-012 uart_busy  in  1  UART is_transmitting status.
REQ-013 owner  out  max(1,clog2(NREQ))  index of the requester holding the lock.
REQ-014 locked  out  1  a requester holds the lock.
REQ-015 timeout_err  out  1  one-cycle pulse: UART failed to start within START_TO.

Function
REQ-016 FSM states SHALL be IDLE, SEND, START, BUSY, GAP.
REQ-017 IDLE: if any req_valid bit is set, owner SHALL be the first set bit at or after round-robin pointer rr (wrapping NREQ-1 -> 0), locked SHALL go 1, next state SEND.
REQ-018 SEND: req_ready[owner] SHALL equal req_valid[owner] combinationally; all other req_ready bits 0; never more than one req_ready bit high.
REQ-019 SEND handshake (valid & ready): byte captured into uart_tx_byte, last flag captured, next state START; uart_tx_byte SHALL stay stable until the next handshake.
REQ-020 SEND with req_valid[owner]=0: stay in SEND, lock held, other requesters not served.
REQ-021 uart_transmit SHALL be 1 for exactly the first cycle of START, 0 otherwise.
REQ-022 START: uart_busy=1 -> BUSY; a cycle counter counts START cycles; after START_TO cycles with uart_busy=0 -> timeout_err pulse, lock released, rr <= owner+1 (wrapped), next state IDLE.
REQ-023 BUSY: remain while uart_busy=1; on uart_busy=0, if captured last=0 -> SEND (same owner); if last=1 -> release lock, rr <= owner+1 (wrapped), next GAP if GAP>0 else IDLE.
REQ-024 GAP: count GAP cycles, then IDLE; no req_ready during GAP.
REQ-025 locked SHALL be 1 exactly in SEND, START, BUSY; owner holds its last value otherwise.
REQ-026 Latency: req_valid rising in IDLE at cycle t -> req_ready at t+1 (if still valid) -> uart_transmit at t+2.
REQ-027 Requester i reasserting valid while j is locked SHALL wait until j's message ends; after release, j has lowest priority.
REQ-028 Simultaneous requests in IDLE: round-robin choice only; no fixed priority.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, rr=0, owner=0, locked=0, uart_transmit=0, uart_tx_byte=0, req_ready=0, timeout_err=0, counters 0, from the next cycle.
REQ-030 Reset mid-message SHALL abandon the message without further transmit pulses; a byte already in the UART is not tracked.

Verification
REQ-031 Single message: req 0 sends 0x41,0x42(last), UART model busy 10 cycles each -> exactly two transmit pulses, bytes 0x41 then 0x42, lock released, rr=1.
REQ-032 Contention: req 0,1,2 valid together from reset, one-byte messages -> service order 0,1,2; then req 0 and 2 together -> 0 served (rr=0 after wrap).
REQ-033 Lock hold: req 1 drops valid mid-message for 20 cycles while req 0 valid -> no req_ready[0] until req 1 sends last byte.
REQ-034 Timeout: uart_busy tied 0 -> timeout_err pulses 16 cycles after transmit pulse (START_TO=16), state IDLE, next requester served.
REQ-035 Gap: GAP=5, two back-to-back messages from req 0 -> 5 cycles with no req_ready between last-byte busy fall and next IDLE grant.
REQ-036 Reset mid-BUSY -> next cycle locked=0, req_ready=0, uart_transmit stays 0 while uart_busy still high.
